rom_load_sequencer: RTL and testbench



---
 rtl/loader_pkg.sv | 30 +++
 rtl/rom_byte_fifo.sv | 74 +++++++
 rtl/rom_load_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_rom_load_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the iNES ROM load sequencer.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    TRAINER,
    PRG,
    CHR,
    DONE,
    ERROR
  } state_t;

  localparam logic [31:0] INES_MAGIC     = 32'h4E45531A;
  localparam int          HEADER_LEN     = 16;
  localparam int          TRAINER_LEN    = 512;
  localparam int          PRG_UNIT_SHIFT = 14;
  localparam int          CHR_UNIT_SHIFT = 13;

  // Magic byte expected at header offset idx (0..3), first byte first.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return INES_MAGIC[31:24];
      2'd1:    return INES_MAGIC[23:16];
      2'd2:    return INES_MAGIC[15:8];
      default: return INES_MAGIC[7:0];
    endcase
  endfunction

endpackage

// File: rtl/rom_byte_fifo.sv
// Synchronous byte FIFO with a registered head (dout valid whenever !empty).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module rom_byte_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_out_vld;
  logic [7:0]    r_dout;

  logic w_pop;
  logic w_push;
  logic w_out_load;
  logic w_stor_empty;
  logic w_stor_rd;
  logic w_bypass;

  assign full         = (r_count == (AW+1)'(FIFO_DEPTH));
  assign empty        = !r_out_vld;
  assign dout         = r_dout;
  assign w_pop        = pop && r_out_vld;
  assign w_push       = push && (!full || w_pop);
  assign w_out_load   = !r_out_vld || w_pop;
  assign w_stor_empty = (r_wr_ptr == r_rd_ptr);
  assign w_stor_rd    = w_out_load && !w_stor_empty;
  // An empty backing store lets a new byte go straight into the head register.
  assign w_bypass     = w_out_load && w_stor_empty && w_push;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_vld <= 1'b0;
      r_dout    <= 8'd0;
    end else begin
      if (w_push && !w_bypass) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_stor_rd) begin
        r_dout    <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_out_vld <= 1'b1;
      end else if (w_bypass) begin
        r_dout    <= din;
        r_out_vld <= 1'b1;
      end else if (w_out_load) begin
        r_out_vld <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rom_load_sequencer.sv
// Parses the iNES header from the SD byte stream and writes PRG/CHR into SDRAM.
// Define ROM_CHECKSUM_EN to add a 16-bit sum of all bytes accepted by memory.
module rom_load_sequencer
  import loader_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [21:0] CHR_BASE      = 22'h200000,
  parameter int          MAX_PRG_UNITS = 128,
  parameter int          MAX_CHR_UNITS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        loading,
  output logic        load_done,
  output logic        load_error,
  output logic [7:0]  mapper,
  output logic        mirroring,
  output logic [7:0]  prg_units,
  output logic [7:0]  chr_units
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  state_t      r_state;
  state_t      w_next;
  logic [21:0] r_cnt;
  logic [21:0] r_addr;
  logic        r_magic_ok;
  logic [7:0]  r_b4;
  logic [7:0]  r_b5;
  logic [3:0]  r_map_lo;
  logic [3:0]  r_map_hi;
  logic        r_trainer;
  logic        r_mirror;
  logic [7:0]  r_mapper;
  logic        r_mirroring;
  logic [7:0]  r_prg_units;
  logic [7:0]  r_chr_units;

  logic        w_active;
  logic        w_push;
  logic        w_pop;
  logic        w_accept;
  logic        w_overflow;
  logic        w_start;
  logic        w_hdr_pop;
  logic        w_hdr_last;
  logic        w_hdr_ok;
  logic        w_region_chg;
  logic [21:0] w_prg_end;
  logic [21:0] w_chr_end;
  logic [7:0]  w_fifo_dout;
  logic        w_fifo_full;
  logic        w_fifo_empty;

  assign w_active   = (r_state == HEADER) || (r_state == TRAINER) ||
                      (r_state == PRG)    || (r_state == CHR);
  assign w_push     = in_valid && w_active;
  assign mem_we     = ((r_state == PRG) || (r_state == CHR)) && !w_fifo_empty;
  assign w_accept   = mem_we && mem_ready;
  assign w_pop      = (((r_state == HEADER) || (r_state == TRAINER)) && !w_fifo_empty) ||
                      w_accept;
  assign w_overflow = w_push && w_fifo_full && !w_pop;
  assign w_hdr_pop  = (r_state == HEADER) && w_pop;
  assign w_hdr_last = w_hdr_pop && (r_cnt == 22'(HEADER_LEN - 1));
  assign w_hdr_ok   = r_magic_ok &&
                      (r_b4 != 8'd0) && (r_b4 <= 8'(MAX_PRG_UNITS)) &&
                      (r_b5 <= 8'(MAX_CHR_UNITS));
  assign w_prg_end  = (22'(r_prg_units) << PRG_UNIT_SHIFT) - 22'd1;
  assign w_chr_end  = (22'(r_chr_units) << CHR_UNIT_SHIFT) - 22'd1;
  assign w_region_chg = (w_next != r_state);

  rom_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .flush(!w_active),
    .push (w_push),
    .din  (in_data),
    .pop  (w_pop),
    .dout (w_fifo_dout),
    .full (w_fifo_full),
    .empty(w_fifo_empty)
  );

  assign mem_din   = w_fifo_dout;
  assign mem_addr  = r_addr;
  assign mapper    = r_mapper;
  assign mirroring = r_mirroring;
  assign prg_units = r_prg_units;
  assign chr_units = r_chr_units;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    loading    = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        load_done  = (r_state == DONE);
        load_error = (r_state == ERROR);
        if (start) begin
          w_next  = HEADER;
          w_start = 1'b1;
        end
      end
      HEADER: begin
        loading = 1'b1;
        if (w_hdr_last) w_next = !w_hdr_ok ? ERROR : (r_trainer ? TRAINER : PRG);
      end
      TRAINER: begin
        loading = 1'b1;
        if (w_pop && (r_cnt == 22'(TRAINER_LEN - 1))) w_next = PRG;
      end
      PRG: begin
        loading = 1'b1;
        if (w_accept && (r_cnt == w_prg_end)) w_next = (r_chr_units != 8'd0) ? CHR : DONE;
      end
      CHR: begin
        loading = 1'b1;
        if (w_accept && (r_cnt == w_chr_end)) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
    if (w_overflow) w_next = ERROR;
  end

  // Region counter and write address restart on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= 22'd0;
      r_addr      <= 22'd0;
      r_magic_ok  <= 1'b0;
      r_mapper    <= 8'd0;
      r_mirroring <= 1'b0;
      r_prg_units <= 8'd0;
      r_chr_units <= 8'd0;
    end else begin
      if (w_region_chg)  r_cnt <= 22'd0;
      else if (w_pop)    r_cnt <= r_cnt + 22'd1;
      if (w_region_chg)  r_addr <= (w_next == CHR) ? CHR_BASE : 22'd0;
      else if (w_accept) r_addr <= r_addr + 22'd1;
      if (w_start) begin
        r_magic_ok  <= 1'b1;
        r_mapper    <= 8'd0;
        r_mirroring <= 1'b0;
        r_prg_units <= 8'd0;
        r_chr_units <= 8'd0;
      end
      if (w_hdr_pop && (r_cnt < 22'd4) && (w_fifo_dout != magic_byte(r_cnt[1:0])))
        r_magic_ok <= 1'b0;
      if (w_hdr_last && w_hdr_ok) begin
        r_mapper    <= {r_map_hi, r_map_lo};
        r_mirroring <= r_mirror;
        r_prg_units <= r_b4;
        r_chr_units <= r_b5;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hdr_pop) begin
      case (r_cnt)
        22'd4: r_b4 <= w_fifo_dout;
        22'd5: r_b5 <= w_fifo_dout;
        22'd6: begin
          r_map_lo  <= w_fifo_dout[7:4];
          r_trainer <= w_fifo_dout[2];
          r_mirror  <= w_fifo_dout[0];
        end
        22'd7:   r_map_hi <= w_fifo_dout[7:4];
        default: ;
      endcase
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset || w_start) r_checksum <= 16'd0;
    else if (w_accept)    r_checksum <= r_checksum + 16'(mem_din);
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Scoreboard bench for rom_load_sequencer: expected SDRAM writes are queued as
// bytes are streamed in and checked by a monitor on every accepted write.
module tb_rom_load_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_ready;
  logic        loading;
  logic        load_done;
  logic        load_error;
  logic [7:0]  mapper;
  logic        mirroring;
  logic [7:0]  prg_units;
  logic [7:0]  chr_units;
`ifdef ROM_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [29:0] sb[$];

  always #5 clk = ~clk;

  rom_load_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .loading   (loading),
    .load_done (load_done),
    .load_error(load_error),
    .mapper    (mapper),
    .mirroring (mirroring),
    .prg_units (prg_units),
    .chr_units (chr_units)
`ifdef ROM_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  function automatic logic [7:0] pat(input int i, input int seed);
    return 8'(i * 3 + (i >> 8) + seed);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic        prev_stall = 1'b0;
    logic [21:0] prev_addr  = '0;
    logic [7:0]  prev_din   = '0;
    logic [29:0] exp_w;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !load_error)
          check("write_hold", 32'({mem_we, mem_addr, mem_din}), 32'({1'b1, prev_addr, prev_din}));
        if (mem_we && mem_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                     mem_addr, mem_din);
          end else begin
            exp_w = sb.pop_front();
            check("write", 32'({mem_addr, mem_din}), 32'(exp_w));
          end
        end
        prev_stall = mem_we && !mem_ready;
        prev_addr  = mem_addr;
        prev_din   = mem_din;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_data  = b;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(gap);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                             input logic [7:0] b6, input logic [7:0] b7);
    send_byte(8'h4E, 0);
    send_byte(8'h45, 0);
    send_byte(8'h53, 0);
    send_byte(b3, 0);
    send_byte(b4, 0);
    send_byte(b5, 0);
    send_byte(b6, 0);
    send_byte(b7, 0);
    for (int k = 0; k < 8; k++) send_byte(8'h00, 0);
  endtask

  task automatic wait_end(input string name, input int max_cyc);
    int k = 0;
    while (!(load_done || load_error) && (k < max_cyc)) begin
      tick(1);
      k++;
    end
    if (!(load_done || load_error)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no load_done/load_error after %0d cycles, required one", name, max_cyc);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    mem_ready = 1'b1;
    fork
      monitor();
    join_none
    tick(3);
    reset = 1'b0;
    tick(1);

    check("reset_flags", 32'({loading, load_done, load_error, mem_we}), 32'h0);
    check("reset_addr_din", 32'({mem_addr, mem_din}), 32'h0);
    check("reset_config", 32'({mapper, mirroring, prg_units, chr_units}), 32'h0);

    // Load 1: 2 PRG units, 1 CHR unit, no trainer.
    do_start();
    check("t1_loading", 32'(loading), 32'h1);
    send_header(8'h1A, 8'h02, 8'h01, 8'h00, 8'h00);
    for (int i = 0; i < 32768; i++) begin
      sb.push_back({22'(i), pat(i, 1)});
      send_byte(pat(i, 1), 0);
    end
    for (int j = 0; j < 8192; j++) begin
      sb.push_back({22'h200000 + 22'(j), pat(j, 77)});
      send_byte(pat(j, 77), 0);
    end
    wait_end("t1", 200);
    check("t1_flags", 32'({loading, load_done, load_error}), 32'b010);
    check("t1_mapper", 32'(mapper), 32'h00);
    check("t1_units", 32'({prg_units, chr_units}), 32'h0201);
    check("t1_mirroring", 32'(mirroring), 32'h0);
    check("t1_drained", 32'(sb.size()), 32'h0);

    // Load 2: trainer present, mapper 0x41, no CHR.
    do_start();
    send_header(8'h1A, 8'h01, 8'h00, 8'h14, 8'h40);
    for (int i = 0; i < 512; i++) send_byte(8'hAA, 0);
    for (int i = 0; i < 16384; i++) begin
      sb.push_back({22'(i), 8'hFF});
      send_byte(8'hFF, 0);
    end
    wait_end("t2", 200);
    check("t2_flags", 32'({loading, load_done, load_error}), 32'b010);
    check("t2_mapper", 32'(mapper), 32'h41);
    check("t2_units", 32'({prg_units, chr_units}), 32'h0100);
    check("t2_drained", 32'(sb.size()), 32'h0);
`ifdef ROM_CHECKSUM_EN
    check("t2_checksum", 32'(checksum), 32'hC000);
`endif

    // Load 3: bad magic byte 3, no write may ever happen.
    do_start();
    check("t3_cleared", 32'({load_done, mapper, prg_units}), 32'h0);
    send_header(8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
    wait_end("t3", 20);
    check("t3_flags", 32'({loading, load_done, load_error}), 32'b001);
    for (int i = 0; i < 4; i++) send_byte(pat(i, 3), 0);
    tick(5);
    check("t3_no_we", 32'(mem_we), 32'h0);

    // Load 4: memory stalled 40 cycles, bytes every 2 cycles -> overflow.
    do_start();
    check("t4_error_cleared", 32'(load_error), 32'h0);
    send_header(8'h1A, 8'h01, 8'h00, 8'h00, 8'h00);
    tick(3);
    mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) send_byte(pat(i, 5), 1);
    check("t4_flags", 32'({loading, load_done, load_error}), 32'b001);
    mem_ready = 1'b1;
    tick(5);
    check("t4_no_we", 32'(mem_we), 32'h0);

    // Load 5: reset mid-PRG, then full reload with a 10-cycle memory stall.
    do_start();
    send_header(8'h1A, 8'h01, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 300; i++) begin
      sb.push_back({22'(i), pat(i, 7)});
      send_byte(pat(i, 7), 0);
    end
    reset = 1'b1;
    sb.delete();
    tick(2);
    reset = 1'b0;
    tick(1);
    check("t5_reset_flags", 32'({loading, load_done, load_error, mem_we}), 32'h0);
    check("t5_reset_config", 32'({mapper, prg_units, mem_addr[15:0]}), 32'h0);
    do_start();
    send_header(8'h1A, 8'h01, 8'h00, 8'h31, 8'h20);
    for (int i = 0; i < 16384; i++) begin
      if (i == 2) mem_ready = 1'b0;
      if (i == 7) mem_ready = 1'b1;
      sb.push_back({22'(i), pat(i, 9)});
      send_byte(pat(i, 9), (i < 20) ? 1 : 0);
    end
    wait_end("t5", 200);
    check("t5_flags", 32'({loading, load_done, load_error}), 32'b010);
    check("t5_mapper", 32'(mapper), 32'h23);
    check("t5_mirroring", 32'(mirroring), 32'h1);
    check("t5_units", 32'({prg_units, chr_units}), 32'h0100);
    check("t5_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
